// File: rtl/qbus_master.sv
// rtl/qbus_master.sv - Q-bus style master: single read/write transactions with rply timeout and DMA handover.
module qbus_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] rdata,
    output logic              sync,
    output logic              din,
    output logic              dout,
    output logic              wtbt,
    output logic              bsy,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic              rply,
    input  logic              dmr,
    output logic              dmgo,
    input  logic              sack
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_XFER,
        S_RELEASE,
        S_ERR,
        S_GRANT,
        S_DMA
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              byte_q;
    logic              write_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rd_capture;

    // Byte reads return the addressed lane right-justified with the upper bits cleared.
    always_comb begin
        rd_capture = data_i;
        if (byte_q) begin
            rd_capture = {{(DATA_W-8){1'b0}}, (addr_q[0] ? data_i[15:8] : data_i[7:0])};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            cnt     <= CNT_INIT;
            rdata   <= '0;
        end else if (ce) begin
            state <= state_next;
            if (state == S_IDLE && (req_rd || req_wr)) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                byte_q  <= req_byte;
                write_q <= !req_rd;
            end
            if (state == S_ADDR) begin
                cnt <= CNT_INIT;
            end else if (state == S_XFER && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_XFER && rply && !write_q) begin
                rdata <= rd_capture;
            end
        end
    end

    always_comb begin
        state_next = state;
        sync       = 1'b0;
        din        = 1'b0;
        dout       = 1'b0;
        wtbt       = 1'b0;
        dmgo       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        addr_o     = '0;
        data_o     = '0;
        case (state)
            S_IDLE: begin
                // A pending CPU request always beats a DMA request in the same cycle.
                if (req_rd || req_wr) begin
                    state_next = S_ADDR;
                end else if (dmr) begin
                    state_next = S_GRANT;
                end
            end
            S_ADDR: begin
                sync       = 1'b1;
                addr_o     = addr_q;
                wtbt       = write_q;
                state_next = S_XFER;
            end
            S_XFER: begin
                sync = 1'b1;
                din  = !write_q;
                dout = write_q;
                wtbt = byte_q;
                if (write_q) begin
                    data_o = wdata_q;
                end
                if (rply) begin
                    state_next = S_RELEASE;
                end else if (cnt == '0) begin
                    state_next = S_ERR;
                end
            end
            S_RELEASE: begin
                if (rply) begin
                    sync = 1'b1;
                end else begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_ERR: begin
                error      = 1'b1;
                state_next = S_IDLE;
            end
            S_GRANT: begin
                dmgo = 1'b1;
                if (sack) begin
                    state_next = S_DMA;
                end else if (!dmr) begin
                    state_next = S_IDLE;
                end
            end
            S_DMA: begin
                if (!sack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign bsy  = sync;

endmodule

// File: tb/tb_qbus_master.sv
// tb/tb_qbus_master.sv - self-checking bench for qbus_master: vector table, random transactions, DMA and reset sequences.
module tb_qbus_master;

    localparam int TO = 63;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        req_rd = 1'b0;
    logic        req_wr = 1'b0;
    logic        req_byte = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [15:0] data_i = '0;
    logic        rply = 1'b0;
    logic        dmr = 1'b0;
    logic        sack = 1'b0;
    logic        busy, done, error, sync, din, dout, wtbt, bsy, dmgo;
    logic [15:0] rdata, addr_o, data_o;

    int checks = 0;
    int errors = 0;
    int ce_mode = 0;
    logic ce_tog = 1'b0;

    qbus_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .req_rd(req_rd), .req_wr(req_wr), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .error(error), .rdata(rdata),
        .sync(sync), .din(din), .dout(dout), .wtbt(wtbt), .bsy(bsy),
        .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .rply(rply),
        .dmr(dmr), .dmgo(dmgo), .sack(sack)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    always @(negedge clk) begin
        #3;
        if (reset_n) begin
            checks++;
            if (bsy !== sync || (done && error)) begin
                errors++;
                $display("FAIL bus_invariant bsy=%b sync=%b done=%b error=%b", bsy, sync, done, error);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pick_ce();
        case (ce_mode)
            0: ce = 1'b1;
            1: begin ce_tog = !ce_tog; ce = ce_tog; end
            default: ce = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Requester plus a simple slave: rply rises after `delay` XFER ce-cycles (-1 = never) and is held `hold` ce-cycles into RELEASE.
    task automatic run_txn(input logic rd, input logic wr, input logic bt,
                           input logic [15:0] a, input logic [15:0] wd, input logic [15:0] di,
                           input int delay, input int hold,
                           output int n_done, output int n_err, output int lat, output int err_k,
                           output logic addr_ok, output logic xfer_ok);
        logic seen_xfer, seen_addr, term, prev_done, prev_err, in_x, in_rel, in_a;
        int k, relk, ce_cnt, post;
        n_done = 0; n_err = 0; lat = -1; err_k = -1; addr_ok = 1'b1; xfer_ok = 1'b1;
        seen_xfer = 1'b0; seen_addr = 1'b0; term = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
        k = 0; relk = 0; ce_cnt = 0; post = 0;
        req_rd = rd; req_wr = wr; req_byte = bt; req_addr = a; req_wdata = wd; data_i = di;
        for (int cyc = 0; cyc < 1000 && post < 4; cyc++) begin
            in_x = din || dout;
            if (in_x) seen_xfer = 1'b1;
            in_rel = seen_xfer && !in_x && busy;
            in_a = !seen_xfer && busy && sync;
            if (in_x) rply = (delay >= 0) && (k >= delay);
            else if (in_rel) rply = (relk < hold);
            else if (in_a) rply = 1'($urandom_range(0, 1));
            else rply = 1'b0;
            #1;
            if (in_a) begin
                seen_addr = 1'b1;
                if (addr_o !== a || wtbt !== (wr && !rd) || din || dout) addr_ok = 1'b0;
            end
            if (in_x) begin
                if (sync !== 1'b1 || din !== rd || dout !== !rd || wtbt !== bt || (!rd && data_o !== wd))
                    xfer_ok = 1'b0;
            end
            if (error && (sync || din || dout)) xfer_ok = 1'b0;
            if (done && !prev_done) begin n_done++; if (lat < 0) lat = ce_cnt; end
            if (error && !prev_err) begin n_err++; if (err_k < 0) err_k = k; end
            prev_done = done;
            prev_err = error;
            if (done || error) begin term = 1'b1; req_rd = 1'b0; req_wr = 1'b0; end
            pick_ce();
            if (ce) begin
                ce_cnt++;
                if (in_x) k++;
                if (in_rel) relk++;
                if (term && !busy) post++;
            end
            tick();
        end
        rply = 1'b0;
        addr_ok = addr_ok && seen_addr;
        check("txn_complete", 32'(post >= 4), 32'd1);
    endtask

    function automatic logic [15:0] model_rdata(input logic [15:0] prev, input logic rd,
                                                input logic bt, input logic [15:0] a,
                                                input logic [15:0] di, input int delay);
        if (!rd || delay < 0 || delay > TO) return prev;
        if (!bt) return di;
        if (a % 2 == 1) return di / 256;
        return di % 256;
    endfunction

    typedef struct {
        logic        rd, wr, bt;
        logic [15:0] a, wd, di;
        int          delay, hold;
        logic [15:0] exp_rdata;
        logic        exp_done;
        int          exp_lat;
    } vec_t;

    vec_t tbl[9];

    task automatic apply(input string tag, input vec_t v);
        int nd, ne, lat, ek;
        logic aok, xok;
        run_txn(v.rd, v.wr, v.bt, v.a, v.wd, v.di, v.delay, v.hold, nd, ne, lat, ek, aok, xok);
        check({tag, "_done"}, 32'(nd), 32'(v.exp_done));
        check({tag, "_error"}, 32'(ne), 32'(!v.exp_done));
        check({tag, "_rdata"}, 32'(rdata), 32'(v.exp_rdata));
        if (v.exp_done) check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        else check({tag, "_timeout_cycles"}, 32'(ek), 32'(TO + 1));
        check({tag, "_addr_phase"}, 32'(aok), 32'd1);
        check({tag, "_xfer_phase"}, 32'(xok), 32'd1);
    endtask

    initial begin
        logic [15:0] model_prev;
        vec_t rv;
        int nd, ne, lat, ek;
        logic aok, xok;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 16'o177660, 16'h0000, 16'o123456, 3, 1, 16'o123456, 1'b1, 7};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 16'o001001, 16'h00A5, 16'hFFFF, 2, 0, 16'o123456, 1'b1, 5};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 16'o001001, 16'h0000, 16'hBEEF, 0, 2, 16'h00BE, 1'b1, 5};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'o001000, 16'h0000, 16'hBEEF, 1, 0, 16'h00EF, 1'b1, 4};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'h5555, 16'h9ABC, 5, 1, 16'h9ABC, 1'b1, 9};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h2000, 16'h0000, 16'h1111, -1, 0, 16'h9ABC, 1'b0, 0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 16'h2002, 16'h0000, 16'h2468, 63, 0, 16'h2468, 1'b1, 66};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 16'h2004, 16'h0000, 16'h1357, 64, 0, 16'h2468, 1'b0, 0};
        tbl[8] = '{1'b0, 1'b1, 1'b0, 16'hFFFE, 16'hC3C3, 16'h0000, 1, 0, 16'h2468, 1'b1, 4};

        tick();
        tick();
        check("reset_ctrl", 32'({sync, din, dout, wtbt, dmgo, busy, done, error, bsy}), 32'd0);
        check("reset_data", 32'({rdata, addr_o}), 32'd0);
        check("reset_data_o", 32'(data_o), 32'd0);
        reset_n = 1'b1;

        ce = 1'b0;
        req_rd = 1'b1;
        tick(); tick(); tick();
        check("ce_low_holds", 32'(busy), 32'd0);
        req_rd = 1'b0;

        ce_mode = 0;
        for (int i = 0; i < 9; i++) apply($sformatf("vec%0d", i), tbl[i]);

        ce_mode = 1;
        rv = tbl[0];
        rv.exp_rdata = 16'o123456;
        apply("ce_toggle_read", rv);

        model_prev = 16'o123456;
        for (int i = 0; i < 30; i++) begin
            ce_mode = $urandom_range(0, 2);
            rv.rd = 1'($urandom_range(0, 1));
            rv.wr = rv.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            rv.bt = 1'($urandom_range(0, 1));
            rv.a = 16'($urandom);
            rv.wd = 16'($urandom);
            rv.di = 16'($urandom);
            rv.delay = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
            rv.hold = $urandom_range(0, 3);
            rv.exp_done = (rv.delay >= 0 && rv.delay <= TO);
            rv.exp_rdata = model_rdata(model_prev, rv.rd, rv.bt, rv.a, rv.di, rv.delay);
            rv.exp_lat = rv.delay + rv.hold + 3;
            apply($sformatf("rand%0d", i), rv);
            model_prev = rv.exp_rdata;
        end

        ce_mode = 0;
        ce = 1'b1;
        data_i = 16'h0F0F; req_addr = 16'h0100; req_byte = 1'b0; req_wr = 1'b0;
        req_rd = 1'b1; dmr = 1'b1; rply = 1'b0;
        tick();
        #1 check("dma_addr_phase", 32'({sync, dmgo, busy}), 32'b101);
        tick();
        rply = 1'b1;
        #1 check("dma_xfer_din", 32'({din, dmgo}), 32'b10);
        tick();
        rply = 1'b0;
        #1 check("dma_release_done", 32'({done, sync, dmgo}), 32'b100);
        req_rd = 1'b0;
        tick();
        #1 check("dma_idle_after_read", 32'({busy, dmgo, rdata}), 32'({2'b00, 16'h0F0F}));
        tick();
        #1 check("dma_grant", 32'({dmgo, busy}), 32'b11);
        tick();
        #1 check("dma_grant_waits_sack", 32'(dmgo), 32'd1);
        sack = 1'b1;
        tick();
        req_rd = 1'b1;
        #1 check("dma_active", 32'({dmgo, busy, sync, din, dout}), 32'b01000);
        tick(); tick();
        #1 check("dma_ignores_req", 32'({busy, sync, addr_o}), 32'({2'b10, 16'h0000}));
        req_rd = 1'b0; dmr = 1'b0; sack = 1'b0;
        tick();
        #1 check("dma_exit_idle", 32'({busy, dmgo}), 32'b00);

        dmr = 1'b1;
        tick();
        #1 check("grant_on_dmr", 32'({dmgo, busy}), 32'b11);
        dmr = 1'b0;
        tick();
        #1 check("grant_abandon", 32'({dmgo, busy}), 32'b00);

        req_rd = 1'b1; req_addr = 16'h0200;
        tick(); tick();
        #1 check("rst_pre_xfer", 32'(din), 32'd1);
        reset_n = 1'b0;
        #1 check("rst_async_outputs", 32'({sync, din, dout, wtbt, busy, done, error, dmgo}), 32'd0);
        req_rd = 1'b0;
        tick(); tick();
        check("rst_rdata_cleared", 32'(rdata), 32'd0);
        reset_n = 1'b1;
        tick();
        run_txn(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 16'h7777, 2, 0, nd, ne, lat, ek, aok, xok);
        check("post_rst_done", 32'(nd), 32'd1);
        check("post_rst_error", 32'(ne), 32'd0);
        check("post_rst_rdata", 32'(rdata), 32'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qbus_master.md
QBUS_MASTER -- requirements
Module: qbus_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter TIMEOUT, default 63, ce-cycles to wait for rply before bus error; counter width $clog2(TIMEOUT+1).
REQ-004 SHALL have ports clk, in, 1, clock; reset_n, in, 1, reset (asynchronous, active-low).
REQ-005 SHALL have ports ce (in, 1, clock enable), req_rd (in, 1, read request), req_wr (in, 1, write request), req_byte (in, 1, byte transfer).
REQ-006 SHALL have ports req_addr (in, ADDR_W, request address), req_wdata (in, DATA_W, write data).
REQ-007 SHALL have ports busy (out, 1, transaction or DMA in progress), done (out, 1, one-cycle completion pulse), error (out, 1, one-cycle timeout pulse), rdata (out, DATA_W, read data).
REQ-008 SHALL have bus ports sync, din, dout, wtbt, bsy (out, 1 each), addr_o (out, ADDR_W), data_o (out, DATA_W), data_i (in, DATA_W), rply (in, 1).
REQ-009 SHALL have DMA ports dmr (in, 1, DMA request), dmgo (out, 1, DMA grant), sack (in, 1, DMA master active).

Function
REQ-010 SHALL advance state only on rising clk with ce=1; with ce=0 all registers hold.
REQ-011 SHALL implement states IDLE, ADDR, XFER, RELEASE, ERR, GRANT, DMA.
REQ-012 IDLE: req_rd or req_wr -> latch addr, wdata, byte, direction; go ADDR; busy=1 from next cycle.
REQ-013 IDLE: req_rd and req_wr both high -> read performed, write dropped.
REQ-014 IDLE: request and dmr both high -> request wins; dmr served at next IDLE.
REQ-015 IDLE: dmr high, no request -> GRANT, dmgo=1.
REQ-016 ADDR: sync=1, addr_o=latched address, wtbt=1 for write, 0 for read; one ce-cycle; go XFER; timeout counter loads TIMEOUT.
REQ-017 XFER: sync=1 held, din=1 (read) or dout=1 (write), data_o=latched wdata on write, wtbt=latched byte flag; counter decrements by 1 per ce-cycle.
REQ-018 XFER: rply=1 -> read latches data_i into rdata (byte read: upper DATA_W-8 bits zero, lower byte taken from data_i[15:8] when addr[0]=1, else data_i[7:0]); go RELEASE.
REQ-019 XFER: counter at 0 and rply=0 -> go ERR.
REQ-020 RELEASE: din=dout=0, sync=1 until rply=0, then sync=0, done=1 for one ce-cycle, go IDLE.
REQ-021 ERR: sync=din=dout=0, error=1 for one ce-cycle, rdata unchanged, go IDLE; done not asserted.
REQ-022 GRANT: dmgo=1 until sack=1, then go DMA, dmgo=0; dmr dropped before sack -> IDLE, dmgo=0.
REQ-023 DMA: all bus outputs 0, busy=1; requests ignored until sack=0, then IDLE.
REQ-024 bsy SHALL equal sync; done and error SHALL never be high in the same cycle.
REQ-025 requests arriving while busy=1 SHALL be ignored; the requester holds them until done or error.
REQ-026 rply asserted in IDLE, ADDR, GRANT or DMA SHALL be ignored.

Reset
REQ-027 reset_n=0 SHALL force IDLE asynchronously; sync, din, dout, wtbt, dmgo, busy, done, error=0; rdata, addr_o, data_o=0; counter=TIMEOUT.
REQ-028 reset mid-transaction SHALL abort without done or error; first request after release starts normally.

Verification
REQ-029 word read req_addr=0o177660, rply after 3 cycles, data_i=0o123456 -> sync, din sequence per REQ-016..020; rdata=0o123456; one done pulse.
REQ-030 byte write addr=0o1001, wdata=0x00A5 -> wtbt=1 in ADDR and XFER, dout=1, data_o=0x00A5; done after rply.
REQ-031 read, rply never asserted, TIMEOUT=63 -> error pulse exactly 64 ce-cycles after XFER entry; sync=0; no done.
REQ-032 dmr with req_rd simultaneously -> read completes first, then dmgo=1; sack=1 -> dmgo=0, busy=1; sack=0 -> IDLE.
REQ-033 ce toggling every other clk during a read -> identical state sequence in ce-cycles, no extra pulses.
REQ-034 reset_n pulsed low during XFER -> all bus outputs 0 immediately; next read completes with done.
